// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared CPU/memory-side types and default widths.
//   owner_e     : tag of the response the SRAM returns in the current cycle
//   DEF_ADDR_W  : default byte-address width
//   DEF_DATA_W  : default data width
package cpu_mem_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        RESP_I    = 2'b01,
        RESP_D_RD = 2'b10,
        RESP_D_WR = 2'b11
    } owner_e;
endpackage

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-ported synchronous SRAM between inst fetch and data access.
//   clk, resetn                         : clock, synchronous active-low reset
//   i_req/i_addr -> i_addr_ok           : inst read request and same-cycle grant
//   i_data_ok/i_rdata                   : inst read response, one cycle after grant
//   d_req/d_wr/d_wstrb/d_addr/d_wdata   : data request (read or byte-strobed write)
//   d_addr_ok, d_data_ok/d_rdata        : data grant and response (write ack carries zero data)
//   sram_en/sram_wen/sram_addr/sram_wdata/sram_rdata : SRAM port, read data valid one cycle after sram_en
// Data wins collisions unless inst has been denied STARVE_MAX cycles in a row.
module sram_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_addr_ok,
    output logic                i_data_ok,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_wr,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_addr_ok,
    output logic                d_data_ok,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_wen,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);
    owner_e     state;
    logic [3:0] starve_cnt;
    logic       force_i, gnt_i, gnt_d;

    // Grants are gated by resetn so nothing reaches the SRAM while in reset.
    assign force_i    = i_req & (starve_cnt == 4'(STARVE_MAX));
    assign gnt_d      = resetn & d_req & ~force_i;
    assign gnt_i      = resetn & i_req & ~gnt_d;
    assign i_addr_ok  = gnt_i;
    assign d_addr_ok  = gnt_d;
    assign sram_en    = gnt_i | gnt_d;
    assign sram_addr  = gnt_d ? (d_addr & ~ADDR_W'(3)) : gnt_i ? i_addr : '0;
    assign sram_wen   = (gnt_d & d_wr) ? d_wstrb : '0;
    assign sram_wdata = sram_en ? d_wdata : '0;

    // State may still hold a stale tag during the first reset cycle, so gate with resetn too.
    assign i_data_ok  = resetn & (state == RESP_I);
    assign d_data_ok  = resetn & ((state == RESP_D_RD) | (state == RESP_D_WR));
    assign i_rdata    = i_data_ok ? sram_rdata : '0;
    assign d_rdata    = (resetn & (state == RESP_D_RD)) ? sram_rdata : '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= gnt_i ? RESP_I : gnt_d ? (d_wr ? RESP_D_WR : RESP_D_RD) : IDLE;
            if (gnt_i | ~i_req)
                starve_cnt <= '0;
            else if (gnt_d && starve_cnt < 4'(STARVE_MAX))
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        assert (STARVE_MAX >= 1 && STARVE_MAX <= 15);
    end
endmodule
